// File: rtl/mem_wb_stage_pkg.sv
// ---------------------------------------------------------------------------
// mem_wb_stage_pkg
// Shared definitions for the memory/writeback slice of the 5-stage core:
//   - writeback select encodings (RESULT_*)
//   - wb_regs_t : contents of the MEM/WB pipeline register
//   - wb_select : writeback mux, shared so every user decodes identically
// ---------------------------------------------------------------------------
package mem_wb_stage_pkg;

    localparam logic [1:0] RESULT_ALU = 2'b00;
    localparam logic [1:0] RESULT_MEM = 2'b01;
    localparam logic [1:0] RESULT_PC4 = 2'b10;

    typedef struct packed {
        logic        regwrite;
        logic [4:0]  rd;
        logic [1:0]  resultsrc;
        logic [31:0] aluresult;
        logic [31:0] readdata;
        logic [31:0] pcplus4;
    } wb_regs_t;

    // Writeback mux; the unused encoding 2'b11 yields zero.
    function automatic logic [31:0] wb_select(
        input logic [1:0]  sel,
        input logic [31:0] alu,
        input logic [31:0] mem,
        input logic [31:0] pc4
    );
        logic [31:0] res;
        case (sel)
            RESULT_ALU: res = alu;
            RESULT_MEM: res = mem;
            RESULT_PC4: res = pc4;
            default:    res = 32'h0000_0000;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/mem_wb_stage_data_memory.sv
// ---------------------------------------------------------------------------
// data_memory
// Word-addressed data RAM: synchronous write, asynchronous read, no reset.
// Ports:
//   clk          in   clock, write on posedge
//   we           in   write enable
//   addr[AW-1:0] in   word index
//   wd[31:0]     in   write data
//   rd[31:0]     out  read data (combinational, pre-write value on same edge)
// ---------------------------------------------------------------------------
module data_memory #(
    parameter int DEPTH = 256,
    parameter int AW    = 8
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [31:0]   wd,
    output logic [31:0]   rd
);

    logic [31:0] mem_q [DEPTH];

    // Synchronous word write; contents deliberately survive reset.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[addr] <= wd;
        end
    end

    assign rd = mem_q[addr];

endmodule

// File: rtl/mem_wb_stage.sv
// ---------------------------------------------------------------------------
// mem_wb_stage
// Memory stage plus MEM/WB pipeline register. Performs word loads/stores on
// the internal data memory, registers M-stage results into W and drives the
// writeback mux (resultW feeds the register file and EX forwarding).
// Ports:
//   clk, rst        clock; asynchronous active-high reset
//   regwriteM       M instruction writes the register file
//   memwriteM       M instruction is a store
//   resultsrcM[1:0] writeback select (00 alu, 01 load, 10 pc+4)
//   aluresultM      byte address or ALU result
//   writedataM      store data
//   pcplus4M        return address
//   rdM[4:0]        destination register
//   memerrM         combinational: out-of-range store or load in M
//   regwriteW, rdW, resultsrcW, aluresultW, readdataW, pcplus4W  W registers
//   resultW         writeback mux output (combinational from W registers)
// ---------------------------------------------------------------------------
module mem_wb_stage
    import mem_wb_stage_pkg::*;
#(
    parameter int DEPTH = 256,
    parameter int AW    = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        regwriteM,
    input  logic        memwriteM,
    input  logic [1:0]  resultsrcM,
    input  logic [31:0] aluresultM,
    input  logic [31:0] writedataM,
    input  logic [31:0] pcplus4M,
    input  logic [4:0]  rdM,
    output logic        memerrM,
    output logic        regwriteW,
    output logic [4:0]  rdW,
    output logic [1:0]  resultsrcW,
    output logic [31:0] aluresultW,
    output logic [31:0] readdataW,
    output logic [31:0] pcplus4W,
    output logic [31:0] resultW
);

    logic        in_range_s;
    logic        mem_we_s;
    logic [31:0] mem_rd_s;
    logic [31:0] readdata_s;
    wb_regs_t    w_d;
    wb_regs_t    w_q;

    // Range check, memory error flag and store gating. Writes are held off
    // while rst is high so a store coinciding with reset is dropped.
    always_comb begin
        in_range_s = (aluresultM[31:AW+2] == {(30-AW){1'b0}});
        mem_we_s   = memwriteM & in_range_s & ~rst;
        memerrM    = (memwriteM & ~in_range_s)
                   | ((resultsrcM == RESULT_MEM) & ~in_range_s);
    end

    data_memory #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_dmem (
        .clk  (clk),
        .we   (mem_we_s),
        .addr (aluresultM[AW+1:2]),
        .wd   (writedataM),
        .rd   (mem_rd_s)
    );

    // Load data and MEM/WB next-state; out-of-range loads read as zero.
    always_comb begin
        readdata_s = 32'h0000_0000;
        if (in_range_s) begin
            readdata_s = mem_rd_s;
        end else begin
            readdata_s = 32'h0000_0000;
        end
        w_d.regwrite  = regwriteM;
        w_d.rd        = rdM;
        w_d.resultsrc = resultsrcM;
        w_d.aluresult = aluresultM;
        w_d.readdata  = readdata_s;
        w_d.pcplus4   = pcplus4M;
    end

    // MEM/WB pipeline register: loads every cycle, cleared asynchronously.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            w_q <= {$bits(wb_regs_t){1'b0}};
        end else begin
            w_q <= w_d;
        end
    end

    // W outputs and writeback mux.
    always_comb begin
        regwriteW  = w_q.regwrite;
        rdW        = w_q.rd;
        resultsrcW = w_q.resultsrc;
        aluresultW = w_q.aluresult;
        readdataW  = w_q.readdata;
        pcplus4W   = w_q.pcplus4;
        resultW    = wb_select(w_q.resultsrc, w_q.aluresult, w_q.readdata, w_q.pcplus4);
    end

endmodule

// File: tb/tb_mem_wb_stage.sv
module tb_mem_wb_stage;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        regwriteM = 1'b0;
    logic        memwriteM = 1'b0;
    logic [1:0]  resultsrcM = 2'b00;
    logic [31:0] aluresultM = 32'h0;
    logic [31:0] writedataM = 32'h0;
    logic [31:0] pcplus4M = 32'h0;
    logic [4:0]  rdM = 5'd0;
    logic        memerrM;
    logic        regwriteW;
    logic [4:0]  rdW;
    logic [1:0]  resultsrcW;
    logic [31:0] aluresultW;
    logic [31:0] readdataW;
    logic [31:0] pcplus4W;
    logic [31:0] resultW;

    int total = 0;
    int bad   = 0;

    logic [31:0]  model_mem [int];
    logic [135:0] sb [$];
    logic [135:0] exp_w;
    logic         err;

    mem_wb_stage #(.DEPTH(256), .AW(8)) dut (
        .clk(clk), .rst(rst),
        .regwriteM(regwriteM), .memwriteM(memwriteM), .resultsrcM(resultsrcM),
        .aluresultM(aluresultM), .writedataM(writedataM), .pcplus4M(pcplus4M),
        .rdM(rdM), .memerrM(memerrM),
        .regwriteW(regwriteW), .rdW(rdW), .resultsrcW(resultsrcW),
        .aluresultW(aluresultW), .readdataW(readdataW), .pcplus4W(pcplus4W),
        .resultW(resultW)
    );

    always #5 clk = ~clk;

    function automatic logic [135:0] w_obs();
        return {regwriteW, rdW, resultsrcW, aluresultW, readdataW, pcplus4W, resultW};
    endfunction

    // Drive one M-stage op (called just after a posedge), push the expected
    // W contents from the bench memory model, then advance one clock.
    task automatic step(input logic rw, input logic mw, input logic [1:0] rs,
                        input logic [31:0] alu, input logic [31:0] wd,
                        input logic [31:0] pc4, input logic [4:0] rd,
                        output logic err_o);
        logic        inr;
        logic [31:0] rdv;
        logic [31:0] res;
        int          idx;
        regwriteM = rw; memwriteM = mw; resultsrcM = rs; aluresultM = alu;
        writedataM = wd; pcplus4M = pc4; rdM = rd;
        #1;
        err_o = memerrM;
        inr = (alu < 32'h0000_0400);
        idx = int'(alu[9:2]);
        rdv = (inr && model_mem.exists(idx)) ? model_mem[idx] : 32'h0;
        case (rs)
            2'b00:   res = alu;
            2'b01:   res = rdv;
            2'b10:   res = pc4;
            default: res = 32'h0;
        endcase
        sb.push_back({rw, rd, rs, alu, rdv, pc4, res});
        if (mw && inr) model_mem[idx] = wd;
        @(posedge clk);
        #1;
        memwriteM = 1'b0;
    endtask

    task automatic test_reset;
        repeat (2) @(posedge clk);
        #1;
        total++;
        if (w_obs() !== 136'h0) begin
            bad++; $display("FAIL reset_init got=%h exp=0", w_obs());
        end
        rst = 1'b0;
    endtask

    task automatic test_reset_midrun;
        step(1'b1, 1'b1, 2'b00, 32'h30, 32'h1111_1111, 32'h100, 5'd3, err);
        exp_w = sb.pop_front(); total++;
        if (w_obs() !== exp_w) begin
            bad++; $display("FAIL rst_pre got=%h exp=%h", w_obs(), exp_w);
        end
        // Pending store that must be dropped by reset.
        regwriteM = 1'b1; memwriteM = 1'b1; resultsrcM = 2'b01;
        aluresultM = 32'h30; writedataM = 32'hBAD0_BAD0; pcplus4M = 32'h104; rdM = 5'd4;
        #2;
        rst = 1'b1;
        #1;
        total++;
        if (w_obs() !== 136'h0) begin
            bad++; $display("FAIL rst_async got=%h exp=0", w_obs());
        end
        @(posedge clk);
        #1;
        total++;
        if (w_obs() !== 136'h0) begin
            bad++; $display("FAIL rst_hold got=%h exp=0", w_obs());
        end
        rst = 1'b0;
        memwriteM = 1'b0;
        step(1'b1, 1'b0, 2'b01, 32'h30, 32'h0, 32'h108, 5'd5, err);
        exp_w = sb.pop_front(); total++;
        if (w_obs() !== exp_w) begin
            bad++; $display("FAIL rst_store_dropped got=%h exp=%h", w_obs(), exp_w);
        end
    endtask

    task automatic test_store_load;
        step(1'b0, 1'b1, 2'b00, 32'h10, 32'hDEAD_BEEF, 32'h200, 5'd0, err);
        exp_w = sb.pop_front(); total++;
        if (w_obs() !== exp_w) begin
            bad++; $display("FAIL store got=%h exp=%h", w_obs(), exp_w);
        end
        step(1'b1, 1'b0, 2'b01, 32'h10, 32'h0, 32'h204, 5'd7, err);
        exp_w = sb.pop_front(); total++;
        if (w_obs() !== exp_w || resultW !== 32'hDEAD_BEEF) begin
            bad++; $display("FAIL load got=%h exp=%h", w_obs(), exp_w);
        end
    endtask

    task automatic test_alignment;
        step(1'b0, 1'b1, 2'b00, 32'h20, 32'h1234_5678, 32'h300, 5'd0, err);
        exp_w = sb.pop_front(); total++;
        if (w_obs() !== exp_w) begin
            bad++; $display("FAIL align_store got=%h exp=%h", w_obs(), exp_w);
        end
        step(1'b1, 1'b0, 2'b01, 32'h23, 32'h0, 32'h304, 5'd8, err);
        exp_w = sb.pop_front(); total++;
        if (w_obs() !== exp_w || resultW !== 32'h1234_5678) begin
            bad++; $display("FAIL align_load got=%h exp=%h", w_obs(), exp_w);
        end
    endtask

    task automatic test_range;
        step(1'b0, 1'b1, 2'b00, 32'h0, 32'hA5A5_A5A5, 32'h400, 5'd0, err);
        exp_w = sb.pop_front(); total++;
        if (err !== 1'b0 || w_obs() !== exp_w) begin
            bad++; $display("FAIL range_inr_store err=%b got=%h exp=%h", err, w_obs(), exp_w);
        end
        step(1'b0, 1'b1, 2'b00, 32'h400, 32'h0000_FFFF, 32'h404, 5'd0, err);
        exp_w = sb.pop_front(); total++;
        if (err !== 1'b1 || w_obs() !== exp_w) begin
            bad++; $display("FAIL range_store err=%b got=%h exp=%h", err, w_obs(), exp_w);
        end
        step(1'b1, 1'b0, 2'b01, 32'h400, 32'h0, 32'h408, 5'd9, err);
        exp_w = sb.pop_front(); total++;
        if (err !== 1'b1 || w_obs() !== exp_w || readdataW !== 32'h0) begin
            bad++; $display("FAIL range_load err=%b got=%h exp=%h", err, w_obs(), exp_w);
        end
        step(1'b1, 1'b0, 2'b01, 32'h0, 32'h0, 32'h40C, 5'd9, err);
        exp_w = sb.pop_front(); total++;
        if (w_obs() !== exp_w || readdataW !== 32'hA5A5_A5A5) begin
            bad++; $display("FAIL range_mem_unchanged got=%h exp=%h", w_obs(), exp_w);
        end
    endtask

    task automatic test_mux;
        step(1'b1, 1'b0, 2'b00, 32'h7, 32'h0, 32'h500, 5'd0, err);
        exp_w = sb.pop_front(); total++;
        if (w_obs() !== exp_w || resultW !== 32'h7) begin
            bad++; $display("FAIL mux_alu got=%h exp=%h", w_obs(), exp_w);
        end
        step(1'b1, 1'b0, 2'b10, 32'h9, 32'h0, 32'h44, 5'd1, err);
        exp_w = sb.pop_front(); total++;
        if (w_obs() !== exp_w || resultW !== 32'h44) begin
            bad++; $display("FAIL mux_pc4 got=%h exp=%h", w_obs(), exp_w);
        end
        step(1'b1, 1'b0, 2'b11, 32'h9, 32'h0, 32'h48, 5'd31, err);
        exp_w = sb.pop_front(); total++;
        if (w_obs() !== exp_w || resultW !== 32'h0) begin
            bad++; $display("FAIL mux_11 got=%h exp=%h", w_obs(), exp_w);
        end
    endtask

    task automatic test_rdw;
        step(1'b0, 1'b1, 2'b00, 32'h10, 32'h1, 32'h600, 5'd0, err);
        void'(sb.pop_front());
        step(1'b0, 1'b1, 2'b01, 32'h10, 32'h2, 32'h604, 5'd0, err);
        exp_w = sb.pop_front(); total++;
        if (w_obs() !== exp_w || readdataW !== 32'h1) begin
            bad++; $display("FAIL rdw_old got=%h exp=%h", w_obs(), exp_w);
        end
        step(1'b1, 1'b0, 2'b01, 32'h10, 32'h0, 32'h608, 5'd2, err);
        exp_w = sb.pop_front(); total++;
        if (w_obs() !== exp_w || readdataW !== 32'h2) begin
            bad++; $display("FAIL rdw_new got=%h exp=%h", w_obs(), exp_w);
        end
    endtask

    task automatic test_back_to_back;
        logic [31:0] alu;
        logic [1:0]  rs;
        logic        mw;
        logic        exp_err;
        for (int i = 0; i < 40; i++) begin
            alu = (32'($urandom_range(0, 300)) << 2) | 32'($urandom_range(0, 3));
            rs  = 2'($urandom_range(0, 3));
            mw  = 1'($urandom_range(0, 1));
            exp_err = (mw || rs == 2'b01) && (alu >= 32'h400);
            step(1'($urandom_range(0, 1)), mw, rs, alu, $urandom, $urandom,
                 5'($urandom_range(0, 31)), err);
            exp_w = sb.pop_front(); total++;
            if (w_obs() !== exp_w || err !== exp_err) begin
                bad++;
                $display("FAIL b2b[%0d] err=%b/%b got=%h exp=%h", i, err, exp_err, w_obs(), exp_w);
            end
        end
    endtask

    initial begin
        test_reset;
        test_store_load;
        test_reset_midrun;
        test_alignment;
        test_range;
        test_mux;
        test_rdw;
        test_back_to_back;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
